aes192_key_expander: RTL

//  Sequential AES-192 key schedule (FIPS-197 5.2). Accepts a 192-bit cipher key and

---
 rtl/aes192_key_expander.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/aes192_key_expander.sv
// AES-192 key schedule, one 32-bit word per cycle, 13 round keys out on a valid/ready stream.
// Optional AES192_REVERSE_EN adds a rev input and a key store for decrypt-order emission.
module aes192_key_expander (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [191:0] cipher_key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] round_key,
  output logic [3:0]   rk_index,
  output logic         rk_last
`ifdef AES192_REVERSE_EN
  ,
  input  logic         rev
`endif
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] b;
    b = {~x, 3'b000};
    return SBOX[b +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, GEN, EMIT, REMIT} state_t;

  state_t       state_q, state_d;
  logic [31:0]  win [6];
  logic [95:0]  stg;
  logic [5:0]   wi;
  logic [2:0]   m6;
  logic [7:0]   rcon;
  logic [3:0]   r;
  logic         rev_mode;
  logic [127:0] rev_key;

  logic [31:0]  rot, sub, t, w_new;
  logic         last_word, accept, hs;

  assign key_ready = (state_q == IDLE);
  assign accept    = key_valid && key_ready;
  assign hs        = rk_valid && rk_ready;
  assign last_word = (wi[1:0] == 2'd3);
  assign rk_last   = rk_valid &&
                     (rk_index == (rev_mode ? 4'd0 : 4'd12));

  // window slot 0 is w[i-6], slot 5 is w[i-1]
  always_comb begin
    rot   = {win[5][23:0], win[5][31:24]};
    sub   = {sbox(rot[31:24]), sbox(rot[23:16]),
             sbox(rot[15:8]),  sbox(rot[7:0])};
    t     = (m6 == 3'd0) ? (sub ^ {rcon, 24'h0}) : win[5];
    w_new = (wi < 6'd6) ? win[0] : (win[0] ^ t);
  end

`ifdef AES192_REVERSE_EN
  logic [127:0] store [13];
  logic         rev_q;
  logic [3:0]   idx_dn;

  assign idx_dn   = rk_index - 4'd1;
  assign rev_mode = rev_q;
  assign rev_key  = store[idx_dn];

  always_ff @(posedge clk) begin
    if (state_q == GEN && last_word && rev_q)
      store[r] <= {stg, w_new};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rev_q <= 1'b0;
    else if (accept) rev_q <= rev;
  end
`else
  assign rev_mode = 1'b0;
  assign rev_key  = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = GEN;
      GEN: begin
        if (last_word) begin
          if (!rev_mode)        state_d = EMIT;
          else if (r == 4'd12)  state_d = REMIT;
        end
      end
      EMIT:  if (hs) state_d = (r == 4'd12) ? IDLE : GEN;
      REMIT: if (hs && rk_index == 4'd0) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 6; k++) win[k] <= '0;
      stg       <= '0;
      wi        <= '0;
      m6        <= '0;
      rcon      <= 8'h01;
      r         <= '0;
      rk_valid  <= 1'b0;
      round_key <= '0;
      rk_index  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            for (int k = 0; k < 6; k++)
              win[k] <= cipher_key[191-32*k -: 32];
            wi   <= '0;
            m6   <= '0;
            rcon <= 8'h01;
            r    <= '0;
          end
        end
        GEN: begin
          for (int k = 0; k < 5; k++) win[k] <= win[k+1];
          win[5] <= w_new;
          stg    <= {stg[63:0], w_new};
          if (wi != 6'd51) wi <= wi + 6'd1;
          m6 <= (m6 == 3'd5) ? 3'd0 : m6 + 3'd1;
          if (m6 == 3'd0 && wi != 6'd0)
            rcon <= {rcon[6:0], 1'b0};
          if (last_word) begin
            if (!rev_mode || r == 4'd12) begin
              round_key <= {stg, w_new};
              rk_index  <= r;
              rk_valid  <= 1'b1;
            end else begin
              r <= r + 4'd1;
            end
          end
        end
        EMIT: begin
          if (hs) begin
            rk_valid <= 1'b0;
            if (r != 4'd12) r <= r + 4'd1;
          end
        end
        REMIT: begin
          if (hs) begin
            if (rk_index == 4'd0) begin
              rk_valid <= 1'b0;
            end else begin
              rk_index  <= rk_index - 4'd1;
              round_key <= rev_key;
            end
          end
        end
      endcase
    end
  end

endmodule
